// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC control sequencer: opcodes, mode constants,
// FSM states and the datapath select codes.
package sisc_pkg;

    localparam int unsigned OpNoop = 0;
    localparam int unsigned OpLod  = 1;
    localparam int unsigned OpStr  = 2;
    localparam int unsigned OpSwp  = 3;
    localparam int unsigned OpBra  = 4;
    localparam int unsigned OpBrr  = 5;
    localparam int unsigned OpBne  = 6;
    localparam int unsigned OpBnr  = 7;
    localparam int unsigned OpAlu  = 8;
    localparam int unsigned OpHlt  = 15;

    localparam int unsigned MmImm = 8;

    typedef enum logic [3:0] {
        StStart,
        StFetch,
        StDecode,
        StExecute,
        StMem,
        StWb,
        StWb2,
        StHalt,
        StFault
    } state_e;

    typedef enum logic [1:0] {
        AluReg = 2'b00,
        AluImm = 2'b01,
        AluAbs = 2'b10,
        AluIdx = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        WbAlu   = 2'd0,
        WbMem   = 2'd1,
        WbSwapA = 2'd2,
        WbSwapB = 2'd3
    } wb_sel_e;

    // Memory ops compute an address, everything else an ALU operation.
    function automatic alu_op_e calc_alu_op(input logic is_mem, input logic is_imm);
        if (is_mem) begin
            return is_imm ? AluIdx : AluAbs;
        end
        return is_imm ? AluImm : AluReg;
    endfunction

endpackage

// File: rtl/sisc_br_eval.sv
// Combinational branch evaluation: flags branch opcodes, whether the
// condition mask against the status register makes them taken, and target mode.
module sisc_br_eval
    import sisc_pkg::*;
#(
    parameter int unsigned OP_W = 4,
    parameter int unsigned CC_W = 4
) (
    input  logic [OP_W-1:0] opcode_i,
    input  logic [CC_W-1:0] mm_i,
    input  logic [CC_W-1:0] stat_i,
    output logic            is_br_o,
    output logic            taken_o,
    output logic            abs_o
);

    logic hit;

    always_comb begin
        hit     = |(stat_i & mm_i);
        is_br_o = 1'b0;
        taken_o = 1'b0;
        abs_o   = 1'b0;
        case (opcode_i)
            OP_W'(OpBra): begin is_br_o = 1'b1; taken_o = hit;  abs_o = 1'b1; end
            OP_W'(OpBrr): begin is_br_o = 1'b1; taken_o = hit;  abs_o = 1'b0; end
            OP_W'(OpBne): begin is_br_o = 1'b1; taken_o = !hit; abs_o = 1'b1; end
            OP_W'(OpBnr): begin is_br_o = 1'b1; taken_o = !hit; abs_o = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/sisc_seq_ctrl.sv
// Multi-cycle SISC control sequencer with handshaked memories, memory-wait
// timeout fault, clean halt and a retired-instruction counter.
module sisc_seq_ctrl
    import sisc_pkg::*;
#(
    parameter int unsigned OP_W  = 4,
    parameter int unsigned MM_W  = 4,
    parameter int unsigned CC_W  = 4,
    parameter int unsigned TO_W  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [OP_W-1:0]  opcode,
    input  logic [MM_W-1:0]  mm,
    input  logic [CC_W-1:0]  stat,
    input  logic             im_ack,
    input  logic             dm_ack,
    output logic             im_req,
    output logic             dm_req,
    output logic             dm_we,
    output logic             ir_load,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             br_sel,
    output logic             pc_rst,
    output logic             rf_we,
    output logic             rb_sel,
    output logic [1:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_q, to_d, to_next;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              retire;
    logic              is_br, br_taken, br_abs;
    logic              is_lod, is_str, is_swp, is_alu, is_imm;

    sisc_br_eval #(
        .OP_W (OP_W),
        .CC_W (CC_W)
    ) u_br_eval (
        .opcode_i (opcode),
        .mm_i     (mm),
        .stat_i   (stat),
        .is_br_o  (is_br),
        .taken_o  (br_taken),
        .abs_o    (br_abs)
    );

    always_comb begin
        is_lod  = (opcode == OP_W'(OpLod));
        is_str  = (opcode == OP_W'(OpStr));
        is_swp  = (opcode == OP_W'(OpSwp));
        is_alu  = (opcode == OP_W'(OpAlu));
        is_imm  = (mm == MM_W'(MmImm));
        to_next = to_q + TO_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        to_d     = '0;
        retire   = 1'b0;
        im_req   = 1'b0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        pc_rst   = 1'b0;
        rf_we    = 1'b0;
        rb_sel   = 1'b0;
        alu_op   = AluReg;
        wb_sel   = WbAlu;
        halted   = 1'b0;
        fault    = 1'b0;
        unique case (state_q)
            StStart: begin
                pc_rst  = 1'b1;
                state_d = StFetch;
            end
            StFetch: begin
                im_req = 1'b1;
                if (im_ack) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else begin
                    to_d = to_next;
                    if (&to_next) state_d = StFault;
                end
            end
            StDecode: begin
                rb_sel = is_str | is_swp;
                if (is_br) begin
                    pc_write = br_taken;
                    pc_sel   = br_taken;
                    br_sel   = br_taken & br_abs;
                    state_d  = StFetch;
                    retire   = 1'b1;
                end else if (is_lod | is_str | is_swp | is_alu) begin
                    state_d = StExecute;
                end else if (opcode == OP_W'(OpHlt)) begin
                    state_d = StHalt;
                    retire  = 1'b1;
                end else begin
                    // NOOP and undefined opcodes simply retire.
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StExecute: begin
                alu_op  = calc_alu_op(is_lod | is_str, is_imm);
                rb_sel  = is_swp;
                state_d = (is_lod | is_str) ? StMem : StWb;
            end
            StMem: begin
                dm_req = 1'b1;
                dm_we  = is_str;
                alu_op = calc_alu_op(1'b1, is_imm);
                if (dm_ack) begin
                    state_d = is_str ? StFetch : StWb;
                    retire  = is_str;
                end else begin
                    to_d = to_next;
                    if (&to_next) state_d = StFault;
                end
            end
            StWb: begin
                rf_we = 1'b1;
                if (is_swp) begin
                    wb_sel  = WbSwapA;
                    state_d = StWb2;
                end else begin
                    wb_sel  = is_lod ? WbMem : WbAlu;
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StWb2: begin
                rf_we   = 1'b1;
                wb_sel  = WbSwapB;
                rb_sel  = 1'b1;
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt:  halted = 1'b1;
            StFault: fault  = 1'b1;
            default: state_d = StStart;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= StStart;
            to_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_sisc_seq_ctrl.sv
// Directed bench for sisc_seq_ctrl: walks instruction classes, branch masks,
// memory waits, timeout fault and asynchronous reset.
module tb_sisc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [3:0]  opcode, mm, stat;
    logic        im_ack, dm_ack;
    logic        im_req, dm_req, dm_we, ir_load, pc_write, pc_sel, br_sel, pc_rst;
    logic        rf_we, rb_sel, halted, fault;
    logic [1:0]  alu_op, wb_sel;
    logic [15:0] instr_cnt;

    int checks = 0;
    int errors = 0;

    sisc_seq_ctrl dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .opcode    (opcode),
        .mm        (mm),
        .stat      (stat),
        .im_ack    (im_ack),
        .dm_ack    (dm_ack),
        .im_req    (im_req),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .ir_load   (ir_load),
        .pc_write  (pc_write),
        .pc_sel    (pc_sel),
        .br_sel    (br_sel),
        .pc_rst    (pc_rst),
        .rf_we     (rf_we),
        .rb_sel    (rb_sel),
        .alu_op    (alu_op),
        .wb_sel    (wb_sel),
        .halted    (halted),
        .fault     (fault),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Pack every enable into one word so a single check covers them all.
    function automatic logic [31:0] en_vec();
        return {16'h0, im_req, dm_req, dm_we, ir_load, pc_write, pc_sel, br_sel, pc_rst,
                rf_we, rb_sel, alu_op, wb_sel, halted, fault};
    endfunction

    task automatic do_reset();
        rst_f = 1'b0;
        #1;
        chk("rst_outputs", en_vec(), 32'h0100);
        chk("rst_cnt", {16'h0, instr_cnt}, 0);
        tick();
        rst_f = 1'b1;
        tick();
    endtask

    initial begin
        rst_f  = 1'b1;
        opcode = 4'd0;
        mm     = 4'd0;
        stat   = 4'd0;
        im_ack = 1'b0;
        dm_ack = 1'b0;
        #3;
        do_reset();

        // FETCH with delayed instruction ack
        chk("fetch_wait", {31'h0, im_req}, 1);
        chk("fetch_wait_ld", {31'h0, ir_load}, 0);
        tick();
        chk("fetch_wait2", {31'h0, im_req}, 1);
        im_ack = 1'b1;
        #1;
        chk("fetch_ack_ld", {30'h0, ir_load, pc_write}, 2'b11);
        chk("fetch_ack_sel", {31'h0, pc_sel}, 0);

        // NOOP then HLT
        opcode = 4'd0;
        tick();
        chk("noop_decode", {16'h0, en_vec()[15:0]}, 32'h0);
        tick();
        chk("noop_retire", {16'h0, instr_cnt}, 1);
        opcode = 4'd15;
        tick();
        tick();
        chk("halt_flag", {30'h0, halted, fault}, 2'b10);
        chk("halt_cnt", {16'h0, instr_cnt}, 2);
        tick();
        chk("halt_sticky", en_vec(), 32'h0002);

        // ALU immediate: 4 cycles FETCH to FETCH
        do_reset();
        opcode = 4'd8;
        mm     = 4'd8;
        tick();
        chk("alu_decode_pcw", {31'h0, pc_write}, 0);
        tick();
        chk("alu_exec_op", {30'h0, alu_op}, 2'b01);
        tick();
        chk("alu_wb", {29'h0, rf_we, wb_sel}, 3'b100);
        tick();
        chk("alu_back_fetch", {31'h0, im_req}, 1);
        chk("alu_cnt", {16'h0, instr_cnt}, 1);

        // BRA taken / not taken
        opcode = 4'd4;
        mm     = 4'b0010;
        stat   = 4'b0010;
        tick();
        chk("bra_taken", {29'h0, pc_write, pc_sel, br_sel}, 3'b111);
        tick();
        stat = 4'b0100;
        tick();
        chk("bra_not_taken", {29'h0, pc_write, pc_sel, br_sel}, 3'b000);
        tick();

        // BNR inverse sense, relative target
        opcode = 4'd7;
        tick();
        chk("bnr_taken", {29'h0, pc_write, pc_sel, br_sel}, 3'b110);
        tick();
        stat = 4'b0010;
        tick();
        chk("bnr_not_taken", {31'h0, pc_write}, 0);
        tick();
        chk("br_cnt", {16'h0, instr_cnt}, 5);

        // STR with dm_ack on the 4th MEM cycle
        opcode = 4'd2;
        mm     = 4'd0;
        tick();
        chk("str_decode_rb", {31'h0, rb_sel}, 1);
        tick();
        chk("str_exec_op", {30'h0, alu_op}, 2'b10);
        for (int k = 1; k <= 4; k++) begin
            tick();
            dm_ack = (k == 4);
            #1;
            chk("str_mem_req", {28'h0, dm_req, dm_we, alu_op}, 4'b1110);
        end
        tick();
        dm_ack = 1'b0;
        chk("str_back_fetch", {30'h0, im_req, dm_req}, 2'b10);
        chk("str_cnt", {16'h0, instr_cnt}, 6);

        // LOD indexed, 1-cycle ack
        opcode = 4'd1;
        mm     = 4'd8;
        tick();
        tick();
        chk("lod_exec_op", {30'h0, alu_op}, 2'b11);
        tick();
        chk("lod_mem", {30'h0, dm_req, dm_we}, 2'b10);
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        chk("lod_wb", {28'h0, dm_req, rf_we, wb_sel}, 4'b0101);
        chk("lod_wb_cnt", {16'h0, instr_cnt}, 6);
        tick();
        chk("lod_cnt", {16'h0, instr_cnt}, 7);

        // SWP two-cycle writeback, single retire
        opcode = 4'd3;
        mm     = 4'd0;
        tick();
        chk("swp_decode_rb", {31'h0, rb_sel}, 1);
        tick();
        chk("swp_exec_rb", {29'h0, rb_sel, alu_op}, 3'b100);
        tick();
        chk("swp_wb", {29'h0, rf_we, wb_sel}, 3'b110);
        tick();
        chk("swp_wb2", {28'h0, rf_we, rb_sel, wb_sel}, 4'b1111);
        chk("swp_wb2_cnt", {16'h0, instr_cnt}, 7);
        tick();
        chk("swp_cnt", {16'h0, instr_cnt}, 8);

        // LOD with no dm_ack: 15 wait cycles then FAULT
        opcode = 4'd1;
        tick();
        tick();
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("to_mem_wait", {30'h0, dm_req, fault}, 2'b10);
        end
        tick();
        chk("to_fault", en_vec(), 32'h0001);
        tick();
        chk("to_fault_sticky", {31'h0, fault}, 1);
        chk("to_fault_cnt", {16'h0, instr_cnt}, 8);

        // Async reset in the middle of a STR access
        do_reset();
        opcode = 4'd2;
        tick();
        tick();
        tick();
        chk("mid_mem_req", {30'h0, dm_req, dm_we}, 2'b11);
        #1;
        rst_f = 1'b0;
        #1;
        chk("async_rst_outputs", en_vec(), 32'h0100);
        chk("async_rst_cnt", {16'h0, instr_cnt}, 0);
        tick();
        rst_f = 1'b1;
        tick();
        chk("post_rst_fetch", {31'h0, im_req}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
